regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor to the CPU's general-purpose register file.
- Provides NUM_READ combinational read ports, a byte-lane-masked write port for LWL/LWR-style merges, and a dedicated link-register write path for JAL/BGEZAL/BLTZAL.
- Also holds the HI/LO pair, a per-register pending-load scoreboard for multi-cycle Avalon loads, and optional write-to-read bypass.
- Sits between the decode and writeback logic of the multicycle MIPS core.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W.
- NUM_READ, 2, number of independent read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is visible on read ports; 0 = reads show stored value only.
- LINK_REG, 31, index written by the link path.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- rd_addr  in  NUM_READ*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_READ*DATA_W  packed read data.
- rd_pending  out  NUM_READ  scoreboard bit of each addressed register.
- wr_en  in  1  general write strobe.
- wr_addr  in  ADDR_W  general write address.
- wr_data  in  DATA_W  general write data.
- wr_byteen  in  DATA_W/8  byte-lane enables for the general write.
- link_en  in  1  link write strobe (target LINK_REG, all lanes).
- link_data  in  DATA_W  return address.
- pend_set  in  1  mark pend_addr as awaiting load data.
- pend_addr  in  ADDR_W  register to mark.
- hilo_we  in  2  bit1 = write HI, bit0 = write LO.
- hi_in, lo_in  in  DATA_W each  HI/LO write data.
- hi_out, lo_out  out  DATA_W each  current HI/LO.
- register_v0  out  DATA_W  register 2, for the testbench.
- any_pending  out  1  OR of all scoreboard bits.

Behaviour:
- Reset (synchronous, active-high):
  - All DEPTH registers, HI, LO and scoreboard clear to 0.
  - Consequently rd_data = 0, rd_pending = 0, any_pending = 0, hi_out = lo_out = 0, register_v0 = 0 in the cycle after reset samples high.
  - Reset overrides every other input in the same cycle.
- Register 0:
  - Always reads 0.
  - Writes and pend_set to address 0 are ignored; its pending bit is constantly 0.
- General write:
  - On an edge with wr_en = 1, each byte lane b with wr_byteen[b] = 1 takes wr_data lane b; disabled lanes keep the old value.
  - wr_en with wr_byteen = 0 changes nothing but still clears the pending bit (load completion with nothing to merge).
- Link write:
  - link_en = 1 writes link_data to LINK_REG, all lanes.
  - If wr_en and link_en are both active and wr_addr == LINK_REG, link wins entirely.
  - Otherwise both writes happen in the same cycle.
- Scoreboard:
  - pend_set marks pend_addr pending on the next edge.
  - Any write (general or link) to a register clears its bit on the same edge.
  - Simultaneous clear and set to the same register: set wins, since the new load was issued after the write.
  - rd_pending[k] and any_pending are combinational from the stored bits; a same-cycle clear is not bypassed.
- Read ports:
  - Combinational, zero latency; rd_data[k] = register[rd_addr[k]].
  - BYPASS = 1: if a write targets rd_addr[k] this cycle (non-zero address), rd_data[k] returns the post-merge value that will be stored (link value if link wins).
  - BYPASS = 0: rd_data[k] shows the old value until after the edge.
  - Ports are fully independent; the same address on several ports is legal.
- HI/LO:
  - Each half is written independently on the edge by its hilo_we bit.
  - No bypass: hi_out/lo_out update one cycle after the write.
- Width rules:
  - No arithmetic; data is stored verbatim.
  - Out-of-range LINK_REG (≥ DEPTH) is an elaboration error.
- Latency summary: write-to-read = 0 cycles with BYPASS = 1, 1 cycle without; scoreboard update = 1 cycle.

Test Plan:
- Reset then read all 32 addresses on both ports -> every rd_data = 0, rd_pending = 0, hi_out = lo_out = 0.
- Write 0xDEADBEEF to r5, then byte-masked write 0x11223344 with byteen 4'b0101 to r5 -> r5 = 0xDE22BE44; same-cycle read shows 0xDE22BE44 with BYPASS = 1, 0xDEADBEEF with BYPASS = 0.
- wr_en to r31 = 0x1 together with link_en = 0xBFC00010 -> r31 = 0xBFC00010; repeat with wr_addr = r4 -> r4 = 0x1 and r31 = link value.
- pend_set r8 -> rd_pending = 1 next cycle; later write r8 together with pend_set r8 -> stays pending; write r8 alone -> clears, any_pending = 0.
- Write 0xFFFFFFFF to r0 and pend_set r0 -> r0 reads 0, never pending; write r2 = 0x2A -> register_v0 = 0x2A.
- hilo_we = 2'b10 with hi_in = 0x5 -> hi_out = 0x5 next cycle, lo unchanged; assert reset mid-load with r8 pending -> all state 0 next cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port GPR file with byte-masked write, link write, HI/LO and pending-load scoreboard.
// Reads are combinational (0 cycles, optional write bypass); writes and scoreboard take effect on the edge; no backpressure.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1,
    parameter int LINK_REG = 31
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    output logic [NUM_READ-1:0]          rd_pending,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [DATA_W/8-1:0]          wr_byteen,
    input  logic                         link_en,
    input  logic [DATA_W-1:0]            link_data,
    input  logic                         pend_set,
    input  logic [ADDR_W-1:0]            pend_addr,
    input  logic [1:0]                   hilo_we,
    input  logic [DATA_W-1:0]            hi_in,
    input  logic [DATA_W-1:0]            lo_in,
    output logic [DATA_W-1:0]            hi_out,
    output logic [DATA_W-1:0]            lo_out,
    output logic [DATA_W-1:0]            register_v0,
    output logic                         any_pending
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

    generate
        if (LINK_REG < 0 || LINK_REG >= DEPTH) begin : g_bad_link
            $error("regfile_mp: LINK_REG outside register range");
        end
        if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_bad_width
            $error("regfile_mp: DATA_W must be a non-zero multiple of 8");
        end
        if (NUM_READ < 1 || NUM_READ > 4) begin : g_bad_ports
            $error("regfile_mp: NUM_READ must be 1..4");
        end
        if (ADDR_W < 2) begin : g_bad_addr
            $error("regfile_mp: ADDR_W too small to hold register 2");
        end
    endgenerate

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic [DATA_W-1:0] merged;
    logic              link_we;
    logic              gen_we;

    // Link write takes the whole register when both paths target LINK_REG.
    assign link_we = link_en && (LINK_A != '0);
    assign gen_we  = wr_en && (wr_addr != '0) && !(link_en && (wr_addr == LINK_A));

    always_comb begin
        merged = regs[wr_addr];
        for (int b = 0; b < NB; b++) begin
            if (wr_byteen[b]) merged[b*8 +: 8] = wr_data[b*8 +: 8];
        end
    end

    // A load issued this cycle outranks the write that retires the previous one.
    always_comb begin
        pend_nxt = pend;
        if (wr_en)    pend_nxt[wr_addr]   = 1'b0;
        if (link_en)  pend_nxt[LINK_A]    = 1'b0;
        if (pend_set) pend_nxt[pend_addr] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            pend   <= '0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            if (gen_we)     regs[wr_addr] <= merged;
            if (link_we)    regs[LINK_A]  <= link_data;
            pend <= pend_nxt;
            if (hilo_we[1]) hi_out <= hi_in;
            if (hilo_we[0]) lo_out <= lo_in;
        end
    end

    generate
        for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] v;
            assign a = rd_addr[k*ADDR_W +: ADDR_W];
            always_comb begin
                v = (a == '0) ? '0 : regs[a];
                if (BYPASS != 0) begin
                    if (link_we && (a == LINK_A))     v = link_data;
                    else if (gen_we && (a == wr_addr)) v = merged;
                end
            end
            assign rd_data[k*DATA_W +: DATA_W] = v;
            assign rd_pending[k] = pend[a];
        end
    endgenerate

    assign register_v0 = regs[2];
    assign any_pending = |pend;
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: bypassing and non-bypassing instances share stimulus.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_pending, rd_pending_nb;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_byteen;
    logic        link_en;
    logic [31:0] link_data;
    logic        pend_set;
    logic [4:0]  pend_addr;
    logic [1:0]  hilo_we;
    logic [31:0] hi_in, lo_in;
    logic [31:0] hi_out, lo_out, register_v0;
    logic [31:0] hi_out_nb, lo_out_nb, register_v0_nb;
    logic        any_pending, any_pending_nb;

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pending(rd_pending),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byteen(wr_byteen),
        .link_en(link_en), .link_data(link_data), .pend_set(pend_set), .pend_addr(pend_addr),
        .hilo_we(hilo_we), .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out),
        .register_v0(register_v0), .any_pending(any_pending));

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_pending(rd_pending_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byteen(wr_byteen),
        .link_en(link_en), .link_data(link_data), .pend_set(pend_set), .pend_addr(pend_addr),
        .hilo_we(hilo_we), .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out_nb), .lo_out(lo_out_nb),
        .register_v0(register_v0_nb), .any_pending(any_pending_nb));

    typedef struct {
        logic [31:0] rd0, rd1, nb0, nb1, hi, lo, v0;
        logic [1:0]  pend;
        logic        anyp;
        bit          lit_en;
        logic [31:0] lit_d, lit_dnb;
        logic        lit_p;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mreg [32];
    logic [31:0] mpend;
    logic [31:0] mhi, mlo;
    int          vectors = 0;
    int          errors  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp) begin
            if (link_en && a == 5'd31) return link_data;
            if (wr_en && a == wr_addr) return merge(mreg[a], wr_data, wr_byteen);
        end
        return mreg[a];
    endfunction

    task automatic model_update();
        if (reset) begin
            for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
            mpend = 32'h0; mhi = 32'h0; mlo = 32'h0;
        end else begin
            if (wr_en && wr_addr != 0 && !(link_en && wr_addr == 5'd31))
                mreg[wr_addr] = merge(mreg[wr_addr], wr_data, wr_byteen);
            if (link_en) mreg[31] = link_data;
            if (wr_en)    mpend[wr_addr]   = 1'b0;
            if (link_en)  mpend[31]        = 1'b0;
            if (pend_set) mpend[pend_addr] = 1'b1;
            mpend[0] = 1'b0;
            if (hilo_we[1]) mhi = hi_in;
            if (hilo_we[0]) mlo = lo_in;
        end
    endtask

    // One clock: push expectations for the driven inputs, compare mid-cycle, then advance the model.
    task automatic apply(input bit le, input logic [31:0] ld, input logic [31:0] ldnb, input logic lp);
        exp_t e;
        exp_t g;
        e.rd0  = exp_rd(rd_addr[4:0], 1'b1);
        e.rd1  = exp_rd(rd_addr[9:5], 1'b1);
        e.nb0  = exp_rd(rd_addr[4:0], 1'b0);
        e.nb1  = exp_rd(rd_addr[9:5], 1'b0);
        e.pend = {mpend[rd_addr[9:5]], mpend[rd_addr[4:0]]};
        e.anyp = |mpend;
        e.hi = mhi; e.lo = mlo; e.v0 = mreg[2];
        e.lit_en = le; e.lit_d = ld; e.lit_dnb = ldnb; e.lit_p = lp;
        exp_q.push_back(e);
        @(negedge clk);
        g = exp_q.pop_front();
        check("rd0",      rd_data[31:0],     g.rd0);
        check("rd1",      rd_data[63:32],    g.rd1);
        check("rd0_nb",   rd_data_nb[31:0],  g.nb0);
        check("rd1_nb",   rd_data_nb[63:32], g.nb1);
        check("pend",     {30'h0, rd_pending},    {30'h0, g.pend});
        check("pend_nb",  {30'h0, rd_pending_nb}, {30'h0, g.pend});
        check("any",      {31'h0, any_pending},   {31'h0, g.anyp});
        check("any_nb",   {31'h0, any_pending_nb},{31'h0, g.anyp});
        check("hi",       hi_out, g.hi);
        check("lo",       lo_out, g.lo);
        check("hi_nb",    hi_out_nb, g.hi);
        check("lo_nb",    lo_out_nb, g.lo);
        check("v0",       register_v0, g.v0);
        check("v0_nb",    register_v0_nb, g.v0);
        if (g.lit_en) begin
            check("lit_rd0",    rd_data[31:0], g.lit_d);
            check("lit_rd0_nb", rd_data_nb[31:0], g.lit_dnb);
            check("lit_pend",   {31'h0, rd_pending[0]}, {31'h0, g.lit_p});
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic quiet();
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_byteen = '0;
        link_en = 1'b0; link_data = '0; pend_set = 1'b0; pend_addr = '0;
        hilo_we = '0; hi_in = '0; lo_in = '0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_byteen = be;
    endtask

    initial begin
        quiet();
        rd_addr = '0;
        reset = 1'b1;
        @(posedge clk);
        model_update();
        #1;
        quiet();

        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            apply(1'b1, 32'h0, 32'h0, 1'b0);
        end

        rd_addr = {5'd5, 5'd5};
        wr(5'd5, 32'hDEADBEEF, 4'hF);        apply(1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
        wr(5'd5, 32'h11223344, 4'b0101);     apply(1'b1, 32'hDE22BE44, 32'hDEADBEEF, 1'b0);
        quiet();                             apply(1'b1, 32'hDE22BE44, 32'hDE22BE44, 1'b0);

        rd_addr = {5'd4, 5'd31};
        wr(5'd31, 32'h1, 4'hF); link_en = 1'b1; link_data = 32'hBFC00010;
        apply(1'b1, 32'hBFC00010, 32'h0, 1'b0);
        quiet();                             apply(1'b1, 32'hBFC00010, 32'hBFC00010, 1'b0);
        rd_addr = {5'd31, 5'd4};
        wr(5'd4, 32'h1, 4'hF); link_en = 1'b1; link_data = 32'hBFC00020;
        apply(1'b1, 32'h1, 32'h0, 1'b0);
        quiet();                             apply(1'b1, 32'h1, 32'h1, 1'b0);

        rd_addr = {5'd8, 5'd8};
        pend_set = 1'b1; pend_addr = 5'd8;   apply(1'b1, 32'h0, 32'h0, 1'b0);
        quiet();                             apply(1'b1, 32'h0, 32'h0, 1'b1);
        wr(5'd8, 32'h88, 4'hF); pend_set = 1'b1; pend_addr = 5'd8;
        apply(1'b1, 32'h88, 32'h0, 1'b1);
        quiet();                             apply(1'b1, 32'h88, 32'h88, 1'b1);
        wr(5'd8, 32'h99, 4'hF);              apply(1'b1, 32'h99, 32'h88, 1'b1);
        quiet();                             apply(1'b1, 32'h99, 32'h99, 1'b0);

        rd_addr = {5'd9, 5'd9};
        pend_set = 1'b1; pend_addr = 5'd9;   apply(1'b1, 32'h0, 32'h0, 1'b0);
        wr(5'd9, 32'hFF, 4'h0); pend_set = 1'b0;
        apply(1'b1, 32'h0, 32'h0, 1'b1);
        quiet();                             apply(1'b1, 32'h0, 32'h0, 1'b0);

        rd_addr = {5'd0, 5'd0};
        wr(5'd0, 32'hFFFFFFFF, 4'hF); pend_set = 1'b1; pend_addr = 5'd0;
        apply(1'b1, 32'h0, 32'h0, 1'b0);
        quiet();                             apply(1'b1, 32'h0, 32'h0, 1'b0);
        rd_addr = {5'd0, 5'd2};
        wr(5'd2, 32'h2A, 4'hF);              apply(1'b1, 32'h2A, 32'h0, 1'b0);
        quiet();                             apply(1'b1, 32'h2A, 32'h2A, 1'b0);
        check("v0_lit", register_v0, 32'h2A);

        hilo_we = 2'b10; hi_in = 32'h5; lo_in = 32'h7;
        apply(1'b0, 32'h0, 32'h0, 1'b0);
        quiet();                             apply(1'b0, 32'h0, 32'h0, 1'b0);
        check("hi_lit", hi_out, 32'h5);
        check("lo_lit", lo_out, 32'h0);

        rd_addr = {5'd8, 5'd8};
        pend_set = 1'b1; pend_addr = 5'd8;   apply(1'b1, 32'h99, 32'h99, 1'b0);
        reset = 1'b1; pend_set = 1'b1; pend_addr = 5'd8; hilo_we = 2'b11; hi_in = 32'h3;
        apply(1'b1, 32'h99, 32'h99, 1'b1);
        quiet();                             apply(1'b1, 32'h0, 32'h0, 1'b0);
        check("rst_any", {31'h0, any_pending}, 32'h0);
        check("rst_hi", hi_out, 32'h0);

        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 63) == 0);
            wr_en     = $urandom_range(0, 1) == 1;
            wr_addr   = 5'($urandom_range(0, 31));
            wr_data   = $urandom;
            wr_byteen = 4'($urandom_range(0, 15));
            link_en   = ($urandom_range(0, 3) == 0);
            link_data = $urandom;
            pend_set  = $urandom_range(0, 1) == 1;
            pend_addr = 5'($urandom_range(0, 31));
            hilo_we   = 2'($urandom_range(0, 3));
            hi_in     = $urandom;
            lo_in     = $urandom;
            rd_addr   = ($urandom_range(0, 3) == 0) ? {wr_addr, 5'd31} : 10'($urandom_range(0, 1023));
            apply(1'b0, 32'h0, 32'h0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
